// File: rtl/dec_scan.sv
// dec_scan: registered binary-to-one-hot decoder with a timed sweep mode.
//   DIRECT (mode=0): y decodes sel on every enabled clock.
//   SCAN   (mode=1): a start pulse walks a single hot line from 0 to N-1.
//                    Each line is held for DWELL enabled cycles. A one-cycle
//                    done pulse follows the last line.
// Ports:
//   clk, rst_n  rising-edge clock; asynchronous active-low reset
//   mode        0 = DIRECT, 1 = SCAN (only looked at in IDLE)
//   en          DIRECT: decode enable; SCAN: 0 pauses the sweep
//   sel         DIRECT-mode line index
//   start       scan request (IDLE, mode=1)
//   abort       cancels a running scan; suppresses start in IDLE
//   y           registered one-hot or all-zero line select
//   idx         index of the active line
//   busy        scan in progress
//   done        one-cycle pulse on normal scan completion
//
// state | meaning
// IDLE  | direct decode, or waiting for a scan start
// SCAN  | sweeping lines, DWELL enabled cycles per line
module dec_scan #(
  parameter int SEL_W = 2,
  parameter int DWELL = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  en,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  start,
  input  logic                  abort,
  output logic [2**SEL_W-1:0]   y,
  output logic [SEL_W-1:0]      idx,
  output logic                  busy,
  output logic                  done
);

  localparam int N     = 2**SEL_W;
  localparam int CNT_W = $clog2(DWELL) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N - 1);
  localparam logic [N-1:0]     LINE0    = N'(1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [N-1:0]     y_nx;
  logic [SEL_W-1:0] idx_nx;
  logic             busy_nx, done_nx;

  logic start_ok, step, cnt_last, idx_last, finish;

  assign start_ok = mode & start & ~abort;
  assign step     = en & ~abort;
  assign cnt_last = (cnt == CNT_LAST);
  assign idx_last = (idx == IDX_LAST);
  assign finish   = step & cnt_last & idx_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      y     <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      y     <= y_nx;
      idx   <= idx_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = SCAN;
      SCAN:    if (abort || finish) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs; done defaults low so the pulse
  // always clears on the following edge.
  always_comb begin
    cnt_nx  = cnt;
    y_nx    = y;
    idx_nx  = idx;
    busy_nx = busy;
    done_nx = 1'b0;
    case (state)
      IDLE: begin
        if (!mode) begin
          if (en) begin
            y_nx   = LINE0 << sel;
            idx_nx = sel;
          end else begin
            y_nx = '0;
          end
        end else if (start_ok) begin
          y_nx    = LINE0;
          idx_nx  = '0;
          busy_nx = 1'b1;
          cnt_nx  = '0;
        end else begin
          y_nx = '0;
        end
      end
      SCAN: begin
        if (abort) begin
          y_nx    = '0;
          busy_nx = 1'b0;
          cnt_nx  = '0;
        end else if (en) begin
          if (!cnt_last) begin
            cnt_nx = cnt + CNT_W'(1);
          end else if (!idx_last) begin
            cnt_nx = '0;
            idx_nx = idx + SEL_W'(1);
            y_nx   = y << 1;
          end else begin
            // Last line served: the sweep ends instead of wrapping idx.
            cnt_nx  = '0;
            y_nx    = '0;
            busy_nx = 1'b0;
            done_nx = 1'b1;
          end
        end
      end
      default: begin
        y_nx    = '0;
        busy_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dec_scan.sv
module tb_dec_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode, en, start, abort;
  logic [2:0] sel3;

  logic [3:0] y4;
  logic [1:0] idx4;
  logic       busy4, done4;
  logic [7:0] y8;
  logic [2:0] idx8;
  logic       busy8, done8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] y;
    logic [2:0] idx;
    logic       busy;
    logic       done;
    string      name;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];

  always #5 clk = ~clk;

  dec_scan #(.SEL_W(2), .DWELL(3)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .sel(sel3[1:0]),
    .start(start), .abort(abort), .y(y4), .idx(idx4), .busy(busy4), .done(done4)
  );

  dec_scan #(.SEL_W(3), .DWELL(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .sel(sel3),
    .start(start), .abort(abort), .y(y8), .idx(idx8), .busy(busy8), .done(done8)
  );

  task automatic compare(input string name, input logic [7:0] ay, input logic [2:0] ai,
                         input logic ab, input logic ad, input exp_t e);
    checks++;
    if ({ay, ai, ab, ad} !== {e.y, e.idx, e.busy, e.done}) begin
      errors++;
      $display("FAIL %s: got y=%b idx=%0d busy=%b done=%b, want y=%b idx=%0d busy=%b done=%b",
               name, ay, ai, ab, ad, e.y, e.idx, e.busy, e.done);
    end
  endtask

  // Scoreboard monitors: one expected entry per edge it was queued for.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      compare(e.name, {4'b0, y4}, {1'b0, idx4}, busy4, done4, e);
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q8.size() > 0) begin
      e = q8.pop_front();
      compare({"w8_", e.name}, y8, idx8, busy8, done8, e);
    end
  end

  // y must be zero or exactly the line named by idx.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (!((y4 == 4'b0) || (y4 == (4'b1 << idx4))) ||
          !((y8 == 8'b0) || (y8 == (8'b1 << idx8)))) begin
        errors++;
        $display("FAIL onehot_inv: got y4=%b idx4=%0d y8=%b idx8=%0d, want zero or 1<<idx",
                 y4, idx4, y8, idx8);
      end
    end
  end

  task automatic drv(input logic m, input logic e, input logic [2:0] s,
                     input logic st, input logic ab);
    mode = m; en = e; sel3 = s; start = st; abort = ab;
  endtask

  task automatic push4(input logic [7:0] y, input logic [2:0] i, input logic b,
                       input logic d, input string n);
    exp_t e;
    e.y = y; e.idx = i; e.busy = b; e.done = d; e.name = n;
    q4.push_back(e);
  endtask

  task automatic push8(input logic [7:0] y, input logic [2:0] i, input logic b,
                       input logic d, input string n);
    exp_t e;
    e.y = y; e.idx = i; e.busy = b; e.done = d; e.name = n;
    q8.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic now_check(input string n, input logic [7:0] y, input logic [2:0] i,
                           input logic b, input logic d);
    exp_t e;
    e.y = y; e.idx = i; e.busy = b; e.done = d; e.name = n;
    compare(n, {4'b0, y4}, {1'b0, idx4}, busy4, done4, e);
  endtask

  // Scan on the 4-line / DWELL=3 instance. Expected line = enabled edges
  // since start / 3; done after the 12th enabled edge.
  task automatic run_scan(input int pause_from, input int pause_len,
                          input int abort_at, input bit noise);
    int ecnt;
    int line;
    bit pe;
    drv(1, 1, 0, 1, 0);
    push4(8'd1, 3'd0, 1, 0, "scan_start");
    tick();
    ecnt = 0;
    for (int j = 1; j < 40; j++) begin
      pe = !(j >= pause_from && j < pause_from + pause_len);
      if (noise && (j == 4 || j == 7)) drv(0, pe, 3, 1, 0);
      else                             drv(1, pe, 0, 0, 0);
      line = ecnt / 3;
      if (j == abort_at) begin
        abort = 1;
        push4(8'd0, 3'(line), 0, 0, "abort");
        tick();
        drv(1, 1, 0, 0, 0);
        push4(8'd0, 3'(line), 0, 0, "abort_nodone");
        tick();
        return;
      end
      if (pe) ecnt++;
      line = ecnt / 3;
      if (ecnt == 12) begin
        push4(8'd0, 3'd3, 0, 1, "scan_done");
        tick();
        drv(0, 1, 1, 0, 0);
        push4(8'b0010, 3'd1, 0, 0, "done_clear_direct");
        tick();
        return;
      end
      push4(8'(1 << line), 3'(line), 1, 0, pause_len > 0 ? "scan_pause" : "scan");
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0);
    #3;
    now_check("reset", 8'd0, 3'd0, 0, 0);
    tick();
    rst_n = 1'b1;

    for (int s = 0; s < 4; s++) begin
      drv(0, 1, 3'(s), 0, 0);
      push4(8'(1 << s), 3'(s), 0, 0, "direct");
      tick();
    end
    drv(0, 0, 2, 0, 0);
    push4(8'd0, 3'd3, 0, 0, "direct_en0");
    tick();

    run_scan(0, 0, 0, 0);
    run_scan(4, 2, 0, 0);
    run_scan(0, 0, 7, 0);

    drv(1, 1, 0, 1, 1);
    push4(8'd0, 3'd2, 0, 0, "idle_start_abort");
    tick();
    drv(1, 1, 0, 0, 0);
    push4(8'd0, 3'd2, 0, 0, "idle_no_scan");
    tick();

    run_scan(0, 0, 0, 1);

    drv(1, 1, 0, 1, 0);
    push4(8'd1, 3'd0, 1, 0, "rst_scan_start");
    tick();
    drv(1, 1, 0, 0, 0);
    push4(8'd1, 3'd0, 1, 0, "rst_scan");
    tick();
    push4(8'd1, 3'd0, 1, 0, "rst_scan");
    tick();
    push4(8'b0010, 3'd1, 1, 0, "rst_scan");
    tick();
    now_check("pre_reset", 8'b0010, 3'd1, 1, 0);
    rst_n = 1'b0;
    #1;
    now_check("async_reset", 8'd0, 3'd0, 0, 0);
    #2;
    rst_n = 1'b1;
    drv(0, 1, 1, 0, 0);
    push4(8'b0010, 3'd1, 0, 0, "post_reset_direct");
    tick();

    drv(1, 1, 0, 1, 0);
    push8(8'd1, 3'd0, 1, 0, "scan_start");
    tick();
    drv(1, 1, 0, 0, 0);
    for (int j = 1; j < 8; j++) begin
      push8(8'(1 << j), 3'(j), 1, 0, "scan");
      tick();
    end
    push8(8'd0, 3'd7, 0, 1, "scan_done");
    tick();
    push8(8'd0, 3'd7, 0, 0, "done_clear");
    tick();
    tick();

    checks++;
    if (q4.size() + q8.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, want 0", q4.size() + q8.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
